// File: rtl/modulo_n_down_pkg.sv
// Shared types and constants for the modulo-N down counter and its load clamp.
package modulo_n_down_pkg;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    localparam int MODE_WRAP     = 0;
    localparam int MODE_ONE_SHOT = 1;

endpackage

// File: rtl/modulo_n_clamp.sv
// Saturating clamp: passes din_i through when below N, otherwise returns N-1.
module modulo_n_clamp #(
    parameter int N     = 2,
    parameter int WIDTH = $clog2(N)
) (
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o
);

    // One extra bit so N itself is representable when N == 2**WIDTH.
    localparam logic [WIDTH:0]   N_EXT = (WIDTH + 1)'(N);
    localparam logic [WIDTH-1:0] Y_MAX = WIDTH'(N - 1);

    always_comb begin
        dout_o = din_i;
        if ({1'b0, din_i} >= N_EXT) begin
            dout_o = Y_MAX;
        end
    end

endmodule

// File: rtl/modulo_n_down.sv
// Modulo-N down counter with load, optional one-shot halt and borrow pulse.
// Define MODULO_N_DOWN_TC_REG_EN to register tc (one clock later than the wrap/halt decision).
module modulo_n_down
    import modulo_n_down_pkg::*;
#(
    parameter int N        = 2,
    parameter int WIDTH    = $clog2(N),
    parameter int ONE_SHOT = MODE_WRAP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic             ld,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] y,
    output logic             tc,
    output logic             done
);

    localparam logic [WIDTH-1:0] Y_MAX  = WIDTH'(N - 1);
    localparam logic [WIDTH-1:0] Y_ZERO = '0;
    localparam logic [WIDTH-1:0] Y_ONE  = WIDTH'(1);

    state_t           state_q = RUN;
    state_t           state_d;
    logic [WIDTH-1:0] y_q = Y_MAX;
    logic [WIDTH-1:0] y_d;
    logic [WIDTH-1:0] din_clamped;
    logic             tc_now;

    modulo_n_clamp #(
        .N     (N),
        .WIDTH (WIDTH)
    ) u_clamp (
        .din_i  (din),
        .dout_o (din_clamped)
    );

    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        tc_now  = 1'b0;
        if (ld) begin
            y_d     = din_clamped;
            state_d = RUN;
        end else if (ce && state_q == RUN) begin
            if (y_q == Y_ZERO) begin
                // Borrow is suppressed while rst overrides the wrap.
                tc_now = ~rst;
                if (ONE_SHOT == MODE_ONE_SHOT) begin
                    state_d = HALT;
                end else begin
                    y_d = Y_MAX;
                end
            end else begin
                y_d = y_q - Y_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            y_q     <= Y_MAX;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
        end
    end

`ifdef MODULO_N_DOWN_TC_REG_EN
    logic tc_q = 1'b0;

    always_ff @(posedge clk) begin
        if (rst || ld) begin
            tc_q <= 1'b0;
        end else begin
            tc_q <= tc_now;
        end
    end

    assign tc = tc_q;
`else
    assign tc = tc_now;
`endif

    assign y    = y_q;
    assign done = (ONE_SHOT == MODE_ONE_SHOT) && (state_q == HALT);

endmodule

// File: tb/tb_modulo_n_down.sv
// Directed bench: four counter instances (N=5 wrap, N=3 one-shot, N=6 wrap, N=4 wrap).
// With MODULO_N_DOWN_TC_REG_EN defined, tc is expected one clock after its combinational value.
module tb_modulo_n_down;

    logic       clk = 1'b0;
    logic [3:0] rst_v = '0;
    logic [3:0] ld_v  = '0;
    logic [3:0] ce_v  = '0;
    logic [2:0] din_v [4];
    logic [2:0] y_v   [4];
    logic [3:0] tc_v;
    logic [3:0] done_v;
    bit   [3:0] prev_tc = '0;

    int check_cnt = 0;
    int pass_cnt  = 0;

    always #5 clk = ~clk;

    modulo_n_down #(.N(5), .WIDTH(3), .ONE_SHOT(0)) u_a (
        .clk(clk), .rst(rst_v[0]), .ce(ce_v[0]), .ld(ld_v[0]), .din(din_v[0]),
        .y(y_v[0]), .tc(tc_v[0]), .done(done_v[0]));
    modulo_n_down #(.N(3), .WIDTH(3), .ONE_SHOT(1)) u_b (
        .clk(clk), .rst(rst_v[1]), .ce(ce_v[1]), .ld(ld_v[1]), .din(din_v[1]),
        .y(y_v[1]), .tc(tc_v[1]), .done(done_v[1]));
    modulo_n_down #(.N(6), .WIDTH(3), .ONE_SHOT(0)) u_c (
        .clk(clk), .rst(rst_v[2]), .ce(ce_v[2]), .ld(ld_v[2]), .din(din_v[2]),
        .y(y_v[2]), .tc(tc_v[2]), .done(done_v[2]));
    modulo_n_down #(.N(4), .WIDTH(3), .ONE_SHOT(0)) u_d (
        .clk(clk), .rst(rst_v[3]), .ce(ce_v[3]), .ld(ld_v[3]), .din(din_v[3]),
        .y(y_v[3]), .tc(tc_v[3]), .done(done_v[3]));

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        check_cnt++;
        assert (obs === exp) begin
            pass_cnt++;
        end else begin
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock on instance k: drive inputs, check tc before the edge, y/done after it.
    task automatic step(input int k, input bit r, input bit l, input bit c,
                        input logic [2:0] d, input logic [2:0] ey, input bit etc,
                        input bit edn, input string tag);
        rst_v[k] = r;
        ld_v[k]  = l;
        ce_v[k]  = c;
        din_v[k] = d;
        #1;
`ifdef MODULO_N_DOWN_TC_REG_EN
        chk({tag, ".tc"}, {7'd0, tc_v[k]}, {7'd0, prev_tc[k]});
`else
        chk({tag, ".tc"}, {7'd0, tc_v[k]}, {7'd0, etc});
`endif
        @(posedge clk);
        #1;
        chk({tag, ".y"}, {5'd0, y_v[k]}, {5'd0, ey});
        chk({tag, ".done"}, {7'd0, done_v[k]}, {7'd0, edn});
        $display("step %s: rst=%0b ld=%0b ce=%0b din=%0d -> y=%0d done=%0b", tag, r, l, c, d, y_v[k], done_v[k]);
        for (int j = 0; j < 4; j++) prev_tc[j] = (j == k) ? etc : 1'b0;
        rst_v[k] = 1'b0;
        ld_v[k]  = 1'b0;
        ce_v[k]  = 1'b0;
    endtask

    logic [2:0] seq_a [12] = '{3'd3, 3'd2, 3'd1, 3'd0, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd4, 3'd3, 3'd2};
    logic [2:0] y_prev;
    logic [2:0] rst_exp [4] = '{3'd4, 3'd2, 3'd5, 3'd3};

    initial begin
        for (int j = 0; j < 4; j++) din_v[j] = '0;
        #1;
        // Power-up values before any reset.
        for (int j = 0; j < 4; j++) chk($sformatf("pwrup%0d.y", j), {5'd0, y_v[j]}, {5'd0, rst_exp[j]});

        @(negedge clk);
        rst_v = 4'hF;
        ce_v  = 4'hF;
        @(posedge clk);
        #1;
        for (int j = 0; j < 4; j++) begin
            chk($sformatf("rst%0d.y", j), {5'd0, y_v[j]}, {5'd0, rst_exp[j]});
            chk($sformatf("rst%0d.tc", j), {7'd0, tc_v[j]}, 8'd0);
            chk($sformatf("rst%0d.done", j), {7'd0, done_v[j]}, 8'd0);
        end
        rst_v = '0;
        ce_v  = '0;
        prev_tc = '0;

        // A: N=5 wrap, reset then 12 counts.
        step(0, 1, 0, 0, 3'd0, 3'd4, 0, 0, "A.rst");
        y_prev = 3'd4;
        for (int i = 0; i < 12; i++) begin
            step(0, 0, 0, 1, 3'd0, seq_a[i], (y_prev == 3'd0), 0, $sformatf("A.cnt%0d", i));
            y_prev = seq_a[i];
        end
        // y=2 here: saturating load, load beats ce, load at y=0 masks tc.
        step(0, 0, 1, 0, 3'd7, 3'd4, 0, 0, "A.ld7");
        step(0, 0, 1, 1, 3'd2, 3'd2, 0, 0, "A.ld2ce");
        step(0, 0, 0, 1, 3'd0, 3'd1, 0, 0, "A.to1");
        step(0, 0, 0, 1, 3'd0, 3'd0, 0, 0, "A.to0");
        step(0, 0, 1, 1, 3'd3, 3'd3, 0, 0, "A.ld3at0");

        // B: N=3 one-shot.
        step(1, 0, 0, 1, 3'd0, 3'd1, 0, 0, "B.c1");
        step(1, 0, 0, 1, 3'd0, 3'd0, 0, 0, "B.c0");
        step(1, 0, 0, 1, 3'd0, 3'd0, 1, 1, "B.halt");
        step(1, 0, 0, 1, 3'd0, 3'd0, 0, 1, "B.hold1");
        step(1, 0, 0, 1, 3'd0, 3'd0, 0, 1, "B.hold2");
        step(1, 0, 1, 1, 3'd1, 3'd1, 0, 0, "B.ld1");
        step(1, 0, 0, 1, 3'd0, 3'd0, 0, 0, "B.c0b");
        step(1, 0, 0, 1, 3'd0, 3'd0, 1, 1, "B.halt2");
        step(1, 1, 0, 1, 3'd0, 3'd2, 0, 0, "B.rsthalt");

        // C: N=6, reset mid-count beats ld and ce; load boundaries.
        step(2, 0, 0, 1, 3'd0, 3'd4, 0, 0, "C.c4");
        step(2, 0, 0, 1, 3'd0, 3'd3, 0, 0, "C.c3");
        step(2, 0, 0, 1, 3'd0, 3'd2, 0, 0, "C.c2");
        step(2, 1, 1, 1, 3'd1, 3'd5, 0, 0, "C.rstld");
        step(2, 0, 0, 1, 3'd0, 3'd4, 0, 0, "C.c4b");
        step(2, 0, 1, 0, 3'd6, 3'd5, 0, 0, "C.ld6");
        step(2, 0, 1, 0, 3'd0, 3'd0, 0, 0, "C.ld0");
        step(2, 0, 0, 1, 3'd0, 3'd5, 1, 0, "C.wrap");

        // D: N=4, ce gaps, hold at zero, then wrap and following count.
        step(3, 0, 0, 1, 3'd0, 3'd2, 0, 0, "D.g1");
        step(3, 0, 0, 0, 3'd0, 3'd2, 0, 0, "D.g0a");
        step(3, 0, 0, 0, 3'd0, 3'd2, 0, 0, "D.g0b");
        step(3, 0, 0, 1, 3'd0, 3'd1, 0, 0, "D.g1b");
        step(3, 0, 0, 1, 3'd0, 3'd0, 0, 0, "D.to0");
        step(3, 0, 0, 0, 3'd0, 3'd0, 0, 0, "D.hold0");
        step(3, 0, 0, 1, 3'd0, 3'd3, 1, 0, "D.wrap");
        step(3, 0, 0, 1, 3'd0, 3'd2, 0, 0, "D.after");

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
